score_board_ctrl: RTL
=====================

SCORE_BOARD_CTRL -- requirements
Module: score_board_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers; register 0 is never tracked.
REQ-002 SHALL have port clk  input  1  pipeline clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port stall  input  1  hold the whole scoreboard and ignore issue (driven from stall_to_is).
REQ-005 SHALL have port flash  input  1  kill issued-not-yet-executed instructions (driven from flash_to_is_ex).
REQ-006 SHALL have port issue_valid  input  2  per-slot instruction issued this cycle.
REQ-007 SHALL have port issue_wen  input  2  per-slot instruction writes a register.
REQ-008 SHALL have port issue_is_load  input  2  per-slot instruction is a load (result available only at MEM).
REQ-009 SHALL have port issue_dst  input  2xREG_ADDR  per-slot destination register.
REQ-010 SHALL have port src_valid  input  4  operand read enable; operands 0,1 belong to slot 0 and operands 2,3 to slot 1.
REQ-011 SHALL have port src_addr  input  4xREG_ADDR  operand register address.
REQ-012 SHALL have port score_board_data  output  4xSCORE_BOARD_DATA  per-operand bypass source {src, slot}.
REQ-013 SHALL have port src_hazard  output  4  operand not obtainable this cycle.
REQ-014 SHALL have port stall_from_issue  output  1  OR of src_hazard.

Function
REQ-015 SHALL keep one entry per register: state in {IDLE, EX, MEM, CMT}, producing slot (1 bit), and load flag.
REQ-016 SHALL advance every non-IDLE entry EX->MEM->CMT->IDLE once per cycle when stall=0, and SHALL hold all entries when stall=1.
REQ-017 SHALL, when stall=0 and flash=0, load entry issue_dst[i] with state EX, slot i, and load=issue_is_load[i] for each slot with issue_valid[i]&issue_wen[i]&(issue_dst[i]!=0).
REQ-018 SHALL let the new issue win over the advance when both target the same entry, so that the youngest writer is always tracked.
REQ-019 SHALL give slot 1 the entry when both slots write the same register in one cycle.
REQ-020 SHALL, when flash=1 and stall=0, drop both issues and set every entry in state EX to IDLE; MEM and CMT entries SHALL advance normally.
REQ-021 SHALL drive score_board_data combinationally from the current entry: IDLE->SB_REGFILE, EX->SB_EX, MEM->SB_MEM, CMT->SB_CMT, together with the entry slot; address 0 or src_valid=0 SHALL give SB_REGFILE with slot 0.
REQ-022 SHALL assert src_hazard[k] when src_valid[k]=1 and the entry is in state EX with load=1 (load-use hazard).
REQ-023 SHALL assert src_hazard[2] or src_hazard[3] when that operand equals issue_dst[0], issue_valid[0]&issue_wen[0]=1, and the address is nonzero (intra-pair RAW hazard).
REQ-024 SHALL keep all outputs combinational from entry state and current inputs; issue-to-bypass latency SHALL be one cycle (SB_EX on the cycle after issue).

Reset
REQ-025 SHALL set every entry to IDLE, slot 0, and load 0 immediately on rst_n=0, independent of clk.
REQ-026 SHALL drive SB_REGFILE on all operands and deassert src_hazard and stall_from_issue while in reset; an in-flight mid-operation reset SHALL discard all tracking.

Structure
REQ-027 SHALL define SB_SRC (SB_REGFILE, SB_EX, SB_MEM, SB_CMT; 2 bits), the entry state enum, and SCORE_BOARD_DATA {SB_SRC src; logic slot} in the shared defines package, where bypass also consumes them.
REQ-028 SHALL place the per-operand lookup and hazard logic in one sub-module, sb_lookup, instantiated four times.

Verification
REQ-029 SHALL verify: issue slot0 write r5 -> next cycle op r5 gives {SB_EX,0}, then {SB_MEM,0}, then {SB_CMT,0}, then SB_REGFILE.
REQ-030 SHALL verify: slot1 load r7, next cycle op0 reads r7 -> src_hazard[0]=1 and stall_from_issue=1; one cycle later {SB_MEM,1} and no hazard.
REQ-031 SHALL verify: both slots write r3 in the same cycle -> op r3 gives {SB_EX,1}; same-cycle slot0 write r4 with op2=r4 -> src_hazard[2]=1.
REQ-032 SHALL verify: r9 in MEM, stall=1 for 3 cycles -> stays {SB_MEM,x} for those 3 cycles, then CMT.
REQ-033 SHALL verify: r2 in EX and r6 in MEM, flash=1 with issue r8 -> r2 and r8 read SB_REGFILE, r6 reads SB_CMT next cycle.
REQ-034 SHALL verify: r1 in CMT re-issued -> {SB_EX}, not IDLE; issue to r0 -> never tracked; rst_n low mid-stream -> all SB_REGFILE immediately.

Source files
------------

// File: rtl/score_board_ctrl_pkg.sv
// score_board_ctrl_pkg: bypass source codes, entry states and helpers shared by the scoreboard and bypass.
package score_board_ctrl_pkg;
  typedef enum logic [1:0] {SB_REGFILE, SB_EX, SB_MEM, SB_CMT} sb_src_t;
  typedef enum logic [1:0] {ST_IDLE, ST_EX, ST_MEM, ST_CMT} entry_state_t;
  typedef struct packed {
    sb_src_t src;
    logic    slot;
  } score_board_data_t;
  function automatic entry_state_t advance(entry_state_t s, logic kill);
    return (s == ST_EX) ? (kill ? ST_IDLE : ST_MEM) : (s == ST_MEM) ? ST_CMT : ST_IDLE;
  endfunction
  function automatic sb_src_t to_src(entry_state_t s);
    return (s == ST_EX) ? SB_EX : (s == ST_MEM) ? SB_MEM : (s == ST_CMT) ? SB_CMT : SB_REGFILE;
  endfunction
endpackage

// File: rtl/score_board_ctrl_if.sv
// score_board_ctrl_if: issue and operand-lookup signals between the issue stage and the scoreboard.
interface score_board_ctrl_if
  import score_board_ctrl_pkg::*;
#(parameter int AW = 5);
  logic                    stall;
  logic                    flash;
  logic [1:0]              issue_valid;
  logic [1:0]              issue_wen;
  logic [1:0]              issue_is_load;
  logic [1:0][AW-1:0]      issue_dst;
  logic [3:0]              src_valid;
  logic [3:0][AW-1:0]      src_addr;
  score_board_data_t [3:0] score_board_data;
  logic [3:0]              src_hazard;
  logic                    stall_from_issue;
  modport master (
    output stall, flash, issue_valid, issue_wen, issue_is_load, issue_dst, src_valid, src_addr,
    input  score_board_data, src_hazard, stall_from_issue
  );
  modport slave (
    input  stall, flash, issue_valid, issue_wen, issue_is_load, issue_dst, src_valid, src_addr,
    output score_board_data, src_hazard, stall_from_issue
  );
endinterface

// File: rtl/score_board_ctrl_sb_lookup.sv
// sb_lookup: maps one operand's scoreboard entry to a bypass source and flags load-use or intra-pair hazards.
module sb_lookup
  import score_board_ctrl_pkg::*;
#(parameter int AW = 5) (
  input  logic              i_valid,
  input  logic [AW-1:0]     i_addr,
  input  entry_state_t      i_state,
  input  logic              i_slot,
  input  logic              i_load,
  input  logic              i_pair_hit,
  output score_board_data_t o_data,
  output logic              o_hazard
);
  logic w_live;
  assign w_live = i_valid && (i_addr != '0);
  assign o_data.src  = w_live ? to_src(i_state) : SB_REGFILE;
  assign o_data.slot = w_live && i_slot;
  assign o_hazard    = w_live && (((i_state == ST_EX) && i_load) || i_pair_hit);
endmodule

// File: rtl/score_board_ctrl.sv
// score_board_ctrl: per-register pipeline-stage tracker for a dual-issue core, feeding bypass selection
// and issue-stage hazard detection.
module score_board_ctrl
  import score_board_ctrl_pkg::*;
#(parameter int NREG = 32) (
  input logic               clk,
  input logic               rst_n,
  score_board_ctrl_if.slave sb
);
  localparam int AW = $clog2(NREG);
  entry_state_t r_state [NREG];
  logic         r_slot  [NREG];
  logic         r_load  [NREG];
  logic [1:0]   w_wr;
  for (genvar i = 0; i < 2; i++) begin : g_wr
    assign w_wr[i] = sb.issue_valid[i] && sb.issue_wen[i] && (sb.issue_dst[i] != '0);
  end
  // Slot 1 is applied last so it owns the entry when both slots write the same register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int e = 0; e < NREG; e++) begin
        r_state[e] <= ST_IDLE;
        r_slot[e]  <= 1'b0;
        r_load[e]  <= 1'b0;
      end
    end else if (!sb.stall) begin
      for (int e = 1; e < NREG; e++) begin
        r_state[e] <= advance(r_state[e], sb.flash);
        for (int i = 0; i < 2; i++)
          if (!sb.flash && w_wr[i] && (sb.issue_dst[i] == AW'(e))) begin
            r_state[e] <= ST_EX;
            r_slot[e]  <= 1'(i);
            r_load[e]  <= sb.issue_is_load[i];
          end
      end
    end
  for (genvar k = 0; k < 4; k++) begin : g_op
    logic w_pair;
    assign w_pair = (k >= 2) && rst_n && w_wr[0] && (sb.src_addr[k] == sb.issue_dst[0]);
    sb_lookup #(.AW(AW)) u_lookup (
      .i_valid    (sb.src_valid[k]),
      .i_addr     (sb.src_addr[k]),
      .i_state    (r_state[sb.src_addr[k]]),
      .i_slot     (r_slot[sb.src_addr[k]]),
      .i_load     (r_load[sb.src_addr[k]]),
      .i_pair_hit (w_pair),
      .o_data     (sb.score_board_data[k]),
      .o_hazard   (sb.src_hazard[k])
    );
  end
  assign sb.stall_from_issue = |sb.src_hazard;
endmodule
